// File: rtl/demux_1x4_stream_pkg.sv
// Shared constants and types for the 1-to-4 round-robin stream demux.
package demux_1x4_stream_pkg;

  localparam int LANES = 4;

  typedef logic [1:0] lane_ptr_t;

  // Pointer advance: a row boundary restarts distribution at lane 0.
  function automatic lane_ptr_t next_ptr(input lane_ptr_t ptr, input logic last);
    return last ? lane_ptr_t'(0) : ptr + lane_ptr_t'(1);
  endfunction

endpackage

// File: rtl/demux_1x4_stream_if.sv
// Stream bus for the demux: one upstream channel and four downstream lanes.
interface demux_1x4_stream_if
  import demux_1x4_stream_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic                   in_last;
  logic [LANES-1:0]       out_valid;
  logic [LANES-1:0]       out_ready;
  logic [LANES*WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/demux_1x4_stream_lane_buf.sv
// One-entry lane buffer: data register plus full flag, cleared by rst or clear.
module demux_lane_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic             full_reg;
  logic [WIDTH-1:0] data_reg;

  // load only arrives while empty, so it never collides with a drain
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      full_reg <= 1'b0;
    end else if (load) begin
      full_reg <= 1'b1;
    end else if (drain) begin
      full_reg <= 1'b0;
    end
  end

  // Data is a don't-care while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      data_reg <= load_data;
    end
  end

  assign full = full_reg;
  assign data = data_reg;

endmodule

// File: rtl/demux_1x4_stream.sv
// Round-robin 1-to-4 stream demux with per-lane one-entry buffers.
// Optional synchronous flush port enabled by defining DEMUX_FLUSH_EN.
module demux_1x4_stream
  import demux_1x4_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
`ifdef DEMUX_FLUSH_EN
  input  logic flush,
`endif
  demux_1x4_stream_if.slave bus
);

  logic             clear;
  lane_ptr_t        ptr_reg;
  logic [LANES-1:0] full;
  logic [WIDTH-1:0] lane_data [LANES];
  logic             accept;

`ifdef DEMUX_FLUSH_EN
  assign clear = flush;
`else
  assign clear = 1'b0;
`endif

  // Ready depends only on local state (and flush), never on out_ready.
  assign bus.in_ready = !full[ptr_reg] && !clear;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ptr_reg <= '0;
    end else if (accept) begin
      ptr_reg <= next_ptr(ptr_reg, bus.in_last);
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      demux_lane_buf #(
        .WIDTH (WIDTH)
      ) u_lane (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .load      (accept && (ptr_reg == lane_ptr_t'(gi))),
        .load_data (bus.in_data),
        .drain     (bus.out_ready[gi]),
        .full      (full[gi]),
        .data      (lane_data[gi])
      );

      assign bus.out_valid[gi]                 = full[gi];
      assign bus.out_data[gi*WIDTH +: WIDTH]   = lane_data[gi];
    end
  endgenerate

endmodule
